// File: rtl/pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_ramp_ctrl
//
// Duty-cycle sequencer for the range-finder PWM generator. A target duty is
// accepted over a valid/ready handshake, and DUTY_CYCLE is walked toward it in
// steps no larger than STEP_SIZE. Duty only changes on the edge where the
// period counter wraps CYCLE_SIZE -> 0, so the PWM block never sees a
// mid-period glitch. The period counter here runs in lockstep with the PWM
// block's own counter.
//
// Parameters:
//   CYCLE_SIZE   terminal count of the period counter (period = CYCLE_SIZE+1)
//
// Ports:
//   CLK          system clock
//   RST_N        synchronous active-low reset
//   TGT_DUTY     requested duty (0..255)
//   TGT_VALID    target request, held by the requester until TGT_READY
//   TGT_READY    controller can accept a target (IDLE, no ABORT/KILL)
//   STEP_SIZE    max duty change per step, 0 means 1, sampled at accept
//   PERIOD_DIV   PWM periods per step, 0 means 1, sampled at accept
//   ABORT        stop an active ramp and freeze duty; blocks accept in IDLE
//   KILL         (PWM_RAMP_KILL_EN only) force duty to 0 on the next edge
//   DUTY_CYCLE   duty driven to the PWM block
//   PERIOD_START high while the period counter is 0
//   BUSY         ramp in progress (RAMP or FINISH)
//   DONE         one-cycle pulse when DUTY_CYCLE has reached the target
//
// Build option:
//   PWM_RAMP_KILL_EN  adds the KILL input. KILL has priority over ABORT and
//                     accept, forces IDLE and zero duty without waiting for a
//                     period boundary, and never produces DONE.
// -----------------------------------------------------------------------------
module pwm_ramp_ctrl #(
    parameter int CYCLE_SIZE = 256
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] TGT_DUTY,
    input  logic       TGT_VALID,
    output logic       TGT_READY,
    input  logic [7:0] STEP_SIZE,
    input  logic [7:0] PERIOD_DIV,
    input  logic       ABORT,
`ifdef PWM_RAMP_KILL_EN
    input  logic       KILL,
`endif
    output logic [7:0] DUTY_CYCLE,
    output logic       PERIOD_START,
    output logic       BUSY,
    output logic       DONE
);

    localparam int              PC_W    = $clog2(CYCLE_SIZE + 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(CYCLE_SIZE);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RAMP   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state, state_next;
    logic [PC_W-1:0] pc;
    logic [7:0]      duty, duty_next;
    logic [7:0]      tgt, tgt_next;
    logic [7:0]      step, step_next;
    logic [7:0]      div, div_next;
    logic [7:0]      div_cnt, div_cnt_next;

    logic            kill;
    logic            boundary;
    logic            accept;
    logic            going_up;
    logic [8:0]      gap;
    logic [7:0]      move;
    logic [7:0]      stepped;
    logic [7:0]      div_cnt_inc;
    logic            step_due;

`ifdef PWM_RAMP_KILL_EN
    assign kill = KILL;
`else
    assign kill = 1'b0;
`endif

    // The clock edge that ends the cycle with pc == CYCLE_SIZE is the only
    // edge on which the duty register may move.
    assign boundary = (pc == PC_LAST);

    // Ready is gated by RST_N so it reads 0 throughout reset, even after the
    // state register has already settled to IDLE.
    assign TGT_READY = RST_N && (state == IDLE) && !ABORT && !kill;
    assign accept    = TGT_VALID && TGT_READY;

    // Step arithmetic. The gap is formed at 9 bits so the magnitude compare
    // against the step is exact; because the move is clamped to the gap, the
    // 8-bit add/subtract below can neither pass the target nor wrap.
    always_comb begin
        going_up = (tgt > duty);
        if (going_up) begin
            gap = {1'b0, tgt} - {1'b0, duty};
        end else begin
            gap = {1'b0, duty} - {1'b0, tgt};
        end
        if ({1'b0, step} < gap) begin
            move = step;
        end else begin
            move = gap[7:0];
        end
        if (going_up) begin
            stepped = duty + move;
        end else begin
            stepped = duty - move;
        end
    end

    // div_cnt never exceeds div-1 (<= 254), so the increment cannot overflow.
    assign div_cnt_inc = div_cnt + 8'd1;
    assign step_due    = (div_cnt_inc == div);

    // Next-state and datapath logic.
    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        duty_next    = duty;
        tgt_next     = tgt;
        step_next    = step;
        div_next     = div;
        div_cnt_next = div_cnt;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    tgt_next     = TGT_DUTY;
                    step_next    = (STEP_SIZE == 8'd0) ? 8'd1 : STEP_SIZE;
                    div_next     = (PERIOD_DIV == 8'd0) ? 8'd1 : PERIOD_DIV;
                    div_cnt_next = 8'd0;
                    state_next   = (TGT_DUTY == duty) ? FINISH : RAMP;
                end
            end

            RAMP: begin
                // ABORT wins over a coincident step: duty stays where it is.
                if (ABORT) begin
                    state_next = IDLE;
                end else if (boundary) begin
                    if (step_due) begin
                        div_cnt_next = 8'd0;
                        duty_next    = stepped;
                        if (stepped == tgt) begin
                            state_next = FINISH;
                        end
                    end else begin
                        div_cnt_next = div_cnt_inc;
                    end
                end
            end

            FINISH: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // Emergency shutdown overrides everything and is not boundary-aligned.
        if (kill) begin
            state_next = IDLE;
            duty_next  = 8'd0;
        end
    end

    // State and datapath registers.
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update together from values sampled before the edge.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            // NOTE: every register here is control or datapath state that
            // must be defined after reset; there is no storage array that
            // could be left unreset.
            state   <= IDLE;
            pc      <= '0;
            duty    <= 8'd0;
            tgt     <= 8'd0;
            step    <= 8'd1;
            div     <= 8'd1;
            div_cnt <= 8'd0;
        end else begin
            state   <= state_next;
            pc      <= boundary ? '0 : pc + PC_W'(1);
            duty    <= duty_next;
            tgt     <= tgt_next;
            step    <= step_next;
            div     <= div_next;
            div_cnt <= div_cnt_next;
        end
    end

    assign DUTY_CYCLE   = duty;
    assign PERIOD_START = (pc == '0);
    assign BUSY         = (state == RAMP) || (state == FINISH);
    assign DONE         = (state == FINISH);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_ramp_ctrl
//
// Self-checking bench for pwm_ramp_ctrl with CYCLE_SIZE = 15 (16-clock
// period). For each accepted target the bench works out, with plain
// arithmetic, the list of duty values the ramp must pass through and the
// cycle in which each one becomes visible, then compares DUTY_CYCLE, BUSY,
// DONE, TGT_READY and PERIOD_START against that schedule every cycle.
// Define PWM_RAMP_KILL_EN to build and exercise the KILL input.
// -----------------------------------------------------------------------------
module tb_pwm_ramp_ctrl;

    localparam int CYC = 15;
    localparam int PER = CYC + 1;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic [7:0] TGT_DUTY = 8'd0;
    logic       TGT_VALID = 1'b0;
    logic       TGT_READY;
    logic [7:0] STEP_SIZE = 8'd1;
    logic [7:0] PERIOD_DIV = 8'd1;
    logic       ABORT = 1'b0;
`ifdef PWM_RAMP_KILL_EN
    logic       KILL = 1'b0;
`endif
    logic [7:0] DUTY_CYCLE;
    logic       PERIOD_START;
    logic       BUSY;
    logic       DONE;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;     // clocks since the last reset edge; pc == cyc % PER
    int model_duty = 0; // duty the model believes is currently driven

    pwm_ramp_ctrl #(.CYCLE_SIZE(CYC)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .TGT_DUTY     (TGT_DUTY),
        .TGT_VALID    (TGT_VALID),
        .TGT_READY    (TGT_READY),
        .STEP_SIZE    (STEP_SIZE),
        .PERIOD_DIV   (PERIOD_DIV),
        .ABORT        (ABORT),
`ifdef PWM_RAMP_KILL_EN
        .KILL         (KILL),
`endif
        .DUTY_CYCLE   (DUTY_CYCLE),
        .PERIOD_START (PERIOD_START),
        .BUSY         (BUSY),
        .DONE         (DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RST_N) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Idle cycles with no request: nothing may move except the period counter.
    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            TGT_VALID = 1'b0;
            #1;
            checks++;
            if (DUTY_CYCLE !== 8'(model_duty) || BUSY !== 1'b0 || DONE !== 1'b0 || TGT_READY !== 1'b1) begin
                errors++;
                $display("FAIL %s_idle cyc=%0d got duty=%0d busy=%b done=%b ready=%b, want duty=%0d busy=0 done=0 ready=1",
                         tag, cyc, DUTY_CYCLE, BUSY, DONE, TGT_READY, model_duty);
            end
            checks++;
            if (PERIOD_START !== ((cyc % PER) == 0)) begin
                errors++;
                $display("FAIL %s_pstart cyc=%0d got=%b want=%b", tag, cyc, PERIOD_START, (cyc % PER) == 0);
            end
        end
    endtask

    // Accepts one target and tracks the whole ramp cycle by cycle. With
    // stop_at >= 0 it returns in the cycle where that duty first becomes
    // visible, leaving the DUT mid-ramp. With junk set, random requests are
    // driven while busy; they must be ignored.
    task automatic drive_and_track_ramp(input int tgt, input int step, input int div,
                                        input int stop_at, input bit junk, input string tag);
        int eff_step, eff_div, t_acc, first_vis, k, d, mag, mv, done_cyc, last_cyc;
        int exp_duty;
        bit exp_busy, exp_done, exp_ready, exp_ps;
        int vis_cyc[$];
        int vis_val[$];

        eff_step = (step == 0) ? 1 : step;
        eff_div  = (div == 0) ? 1 : div;

        @(negedge CLK);
        TGT_DUTY   = 8'(tgt);
        STEP_SIZE  = 8'(step);
        PERIOD_DIV = 8'(div);
        TGT_VALID  = 1'b1;
        #1;
        checks++;
        if (TGT_READY !== 1'b1) begin
            errors++;
            $display("FAIL %s_accept_ready cyc=%0d got=%b want=1", tag, cyc, TGT_READY);
        end
        t_acc = cyc;

        // Duty changes become visible in cycles with pc == 0 strictly after
        // T+1; the k-th step lands on the (k*div)-th such cycle.
        first_vis = t_acc + 2;
        while ((first_vis % PER) != 0) first_vis++;
        d = model_duty;
        k = 0;
        while (d != tgt) begin
            k++;
            mag = (tgt > d) ? tgt - d : d - tgt;
            mv  = (mag < eff_step) ? mag : eff_step;
            d   = (tgt > d) ? d + mv : d - mv;
            vis_cyc.push_back(first_vis + (k * eff_div - 1) * PER);
            vis_val.push_back(d);
        end
        done_cyc = (k == 0) ? t_acc + 1 : vis_cyc[k-1];
        last_cyc = done_cyc + 2;

        for (int n = t_acc + 1; n <= last_cyc; n++) begin
            @(negedge CLK);
            if (junk && n <= done_cyc) begin
                TGT_VALID  = 1'($urandom_range(0, 1));
                TGT_DUTY   = 8'($urandom);
                STEP_SIZE  = 8'($urandom);
                PERIOD_DIV = 8'($urandom);
            end else begin
                TGT_VALID = 1'b0;
            end
            #1;
            exp_duty = model_duty;
            for (int i = 0; i < vis_cyc.size(); i++)
                if (vis_cyc[i] <= cyc) exp_duty = vis_val[i];
            exp_busy  = (cyc <= done_cyc);
            exp_done  = (cyc == done_cyc);
            exp_ready = !exp_busy;
            exp_ps    = ((cyc % PER) == 0);

            checks++;
            if (DUTY_CYCLE !== 8'(exp_duty)) begin
                errors++;
                $display("FAIL %s_duty cyc=%0d got=%0d want=%0d", tag, cyc, DUTY_CYCLE, exp_duty);
            end
            checks++;
            if (BUSY !== exp_busy) begin
                errors++;
                $display("FAIL %s_busy cyc=%0d got=%b want=%b", tag, cyc, BUSY, exp_busy);
            end
            checks++;
            if (DONE !== exp_done) begin
                errors++;
                $display("FAIL %s_done cyc=%0d got=%b want=%b", tag, cyc, DONE, exp_done);
            end
            checks++;
            if (TGT_READY !== exp_ready) begin
                errors++;
                $display("FAIL %s_ready cyc=%0d got=%b want=%b", tag, cyc, TGT_READY, exp_ready);
            end
            checks++;
            if (PERIOD_START !== exp_ps) begin
                errors++;
                $display("FAIL %s_pstart cyc=%0d got=%b want=%b", tag, cyc, PERIOD_START, exp_ps);
            end

            if (stop_at >= 0 && exp_duty == stop_at && cyc < done_cyc) begin
                TGT_VALID  = 1'b0;
                model_duty = stop_at;
                return;
            end
        end
        model_duty = tgt;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        TGT_VALID = 1'b0;
        ABORT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            checks++;
            if (DUTY_CYCLE !== 8'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || TGT_READY !== 1'b0 || PERIOD_START !== 1'b1) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got duty=%0d busy=%b done=%b ready=%b pstart=%b, want 0 0 0 0 1",
                         i, DUTY_CYCLE, BUSY, DONE, TGT_READY, PERIOD_START);
            end
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        #1;
        checks++;
        if (TGT_READY !== 1'b1 || BUSY !== 1'b0 || DUTY_CYCLE !== 8'd0) begin
            errors++;
            $display("FAIL reset_release got ready=%b busy=%b duty=%0d, want ready=1 busy=0 duty=0",
                     TGT_READY, BUSY, DUTY_CYCLE);
        end
        model_duty = 0;
    endtask

    task automatic test_up_ramp;
        drive_and_track_ramp(10, 4, 1, -1, 1'b0, "up");
        idle_cycles(3, "up");
    endtask

    task automatic test_down_ramp;
        drive_and_track_ramp(200, 255, 1, -1, 1'b0, "to200");
        drive_and_track_ramp(0, 100, 2, -1, 1'b1, "down");
        idle_cycles(2, "down");
    endtask

    task automatic test_equal_and_zero;
        drive_and_track_ramp(model_duty, 9, 2, -1, 1'b0, "equal");
        drive_and_track_ramp(3, 0, 0, -1, 1'b1, "zero_fields");
        drive_and_track_ramp(3, 5, 1, -1, 1'b0, "equal_nonzero");
    endtask

    task automatic test_abort;
        drive_and_track_ramp(0, 255, 1, -1, 1'b0, "abort_prep");
        drive_and_track_ramp(20, 4, 1, 8, 1'b0, "abort_ramp");
        @(negedge CLK);
        ABORT = 1'b1;
        #1;
        checks++;
        if (DUTY_CYCLE !== 8'd8 || BUSY !== 1'b1 || TGT_READY !== 1'b0) begin
            errors++;
            $display("FAIL abort_edge got duty=%0d busy=%b ready=%b, want duty=8 busy=1 ready=0",
                     DUTY_CYCLE, BUSY, TGT_READY);
        end
        // ABORT held together with a request while IDLE: never accepted.
        for (int i = 0; i < 2 * PER; i++) begin
            @(negedge CLK);
            TGT_VALID = 1'b1;
            TGT_DUTY  = 8'd50;
            #1;
            checks++;
            if (DUTY_CYCLE !== 8'd8 || BUSY !== 1'b0 || DONE !== 1'b0 || TGT_READY !== 1'b0) begin
                errors++;
                $display("FAIL abort_hold cyc=%0d got duty=%0d busy=%b done=%b ready=%b, want 8 0 0 0",
                         cyc, DUTY_CYCLE, BUSY, DONE, TGT_READY);
            end
        end
        @(negedge CLK);
        ABORT = 1'b0;
        TGT_VALID = 1'b0;
        model_duty = 8;
        idle_cycles(3, "abort_after");
    endtask

`ifdef PWM_RAMP_KILL_EN
    task automatic test_kill;
        drive_and_track_ramp(0, 255, 1, -1, 1'b0, "kill_prep");
        drive_and_track_ramp(200, 40, 1, 120, 1'b0, "kill_ramp");
        @(negedge CLK);
        KILL = 1'b1;
        #1;
        checks++;
        if (DUTY_CYCLE !== 8'd120 || TGT_READY !== 1'b0) begin
            errors++;
            $display("FAIL kill_edge got duty=%0d ready=%b, want duty=120 ready=0", DUTY_CYCLE, TGT_READY);
        end
        for (int i = 0; i < PER + 3; i++) begin
            @(negedge CLK);
            TGT_VALID = 1'b1;
            ABORT     = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (DUTY_CYCLE !== 8'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || TGT_READY !== 1'b0) begin
                errors++;
                $display("FAIL kill_hold cyc=%0d got duty=%0d busy=%b done=%b ready=%b, want 0 0 0 0",
                         cyc, DUTY_CYCLE, BUSY, DONE, TGT_READY);
            end
        end
        @(negedge CLK);
        KILL = 1'b0;
        ABORT = 1'b0;
        TGT_VALID = 1'b0;
        model_duty = 0;
        idle_cycles(3, "kill_after");
    endtask
`endif

    task automatic test_random;
        int tgt, step, div, mag, eff_step, eff_div, periods;
        for (int r = 0; r < 8; r++) begin
            tgt  = int'($urandom_range(0, 255));
            step = int'($urandom_range(0, 63));
            div  = int'($urandom_range(0, 3));
            eff_step = (step == 0) ? 1 : step;
            eff_div  = (div == 0) ? 1 : div;
            mag = (tgt > model_duty) ? tgt - model_duty : model_duty - tgt;
            periods = ((mag + eff_step - 1) / eff_step) * eff_div;
            if (periods > 30) step = 64;
            idle_cycles(int'($urandom_range(0, 5)), "rand");
            drive_and_track_ramp(tgt, step, div, -1, 1'b1, "rand");
        end
    endtask

    task automatic test_reset_mid_ramp;
        drive_and_track_ramp(0, 255, 1, -1, 1'b0, "rst_prep");
        drive_and_track_ramp(100, 50, 1, 50, 1'b0, "rst_ramp");
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        #1;
        checks++;
        if (DUTY_CYCLE !== 8'd0 || BUSY !== 1'b0 || DONE !== 1'b0 || TGT_READY !== 1'b0 || PERIOD_START !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ramp got duty=%0d busy=%b done=%b ready=%b pstart=%b, want 0 0 0 0 1",
                     DUTY_CYCLE, BUSY, DONE, TGT_READY, PERIOD_START);
        end
        RST_N = 1'b1;
        model_duty = 0;
        @(negedge CLK);
        idle_cycles(PER + 2, "post_reset");
    endtask

    initial begin
        test_reset();
        test_up_ramp();
        test_down_ramp();
        test_equal_and_zero();
        test_abort();
`ifdef PWM_RAMP_KILL_EN
        test_kill();
`endif
        test_random();
        test_reset_mid_ramp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
